// File: rtl/serial_sub3.sv
// serial_sub3: bit-serial subtractor x - y, LSB first, with valid/ready handshakes on both sides
module serial_sub3 #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         ovf
);
  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  logic [1:0]    state;
  logic [W-1:0]  a_sr, b_sr, res;
  logic [CW-1:0] cnt;
  logic          borrow, sx, sy, d;
  assign d = a_sr[0] ^ b_sr[0] ^ borrow;
  // capture operands, then ripple one difference bit and the borrow per edge until W bits are done
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      borrow <= 1'b0;
      res    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      sx     <= 1'b0;
      sy     <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        a_sr   <= x;
        b_sr   <= y;
        sx     <= x[W-1];
        sy     <= y[W-1];
        borrow <= 1'b0;
        res    <= '0;
        cnt    <= '0;
        state  <= SHIFT;
      end
    end else if (state == SHIFT) begin
      borrow <= (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
      res    <= {d, res[W-1:1]};
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      cnt    <= cnt + 1'b1;
      state  <= (cnt == CW'(W - 1)) ? DONE : SHIFT;
    end else begin
      state <= out_ready ? IDLE : state;
    end
  end
  // outputs decode only registered state, so no input reaches an output combinationally
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    diff      = res;
    bout      = borrow;
    ovf       = out_valid & (sx ^ sy) & (res[W-1] ^ sx);
  end
endmodule

// File: tb/tb_serial_sub3.sv
// tb_serial_sub3: directed and exhaustive checks of the serial subtractor with W=3
module tb_serial_sub3;
  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready, bout, ovf;
  logic [2:0] x, y, diff;
  int         errors = 0;
  int         checks = 0;
  int         accepts = 0;
  int         results = 0;
  serial_sub3 #(.W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .out_valid(out_valid), .out_ready(out_ready), .diff(diff), .bout(bout), .ovf(ovf)
  );
  always #5 clk = ~clk;
  // count handshakes as the DUT sees them at the edge
  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) accepts <= accepts + 1;
    if (!rst && out_valid && out_ready) results <= results + 1;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [2:0] xv, input logic [2:0] yv,
                        input int stall, input logic [2:0] ed, input logic eb, input logic eo);
    chk({tag, " in_ready"}, in_ready, 1);
    x = xv;
    y = yv;
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    x = ~xv;
    y = ~yv;
    chk({tag, " busy"}, in_ready, 0);
    step();
    step();
    chk({tag, " early"}, out_valid, 0);
    step();
    chk({tag, " valid"}, out_valid, 1);
    chk({tag, " diff"}, diff, ed);
    chk({tag, " bout"}, bout, eb);
    chk({tag, " ovf"}, ovf, eo);
    for (int i = 0; i < stall; i++) step();
    chk({tag, " hold"}, {out_valid, in_ready, diff, bout, ovf}, {1'b1, 1'b0, ed, eb, eo});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, " back"}, {in_ready, out_valid}, 2'b10);
  endtask
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = '0;
    y = '0;
    step();
    step();
    rst = 1'b0;
    chk("reset", {in_ready, out_valid, diff, bout, ovf}, {1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
    run_op("6-1", 3'd6, 3'd1, 0, 3'd5, 1'b0, 1'b0);
    run_op("2-3", 3'd2, 3'd3, 0, 3'd7, 1'b1, 1'b0);
    run_op("3-4", 3'd3, 3'd4, 0, 3'd7, 1'b1, 1'b1);
    run_op("5-4", 3'd5, 3'd4, 0, 3'd1, 1'b0, 1'b0);
    run_op("4-1", 3'd4, 3'd1, 1, 3'd3, 1'b0, 1'b1);
    x = 3'd0;
    y = 3'd0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      x = 3'(i + 3);
      y = 3'(i + 1);
      in_valid = 1'b1;
      chk("bp hold", {out_valid, in_ready, diff, bout}, {1'b1, 1'b0, 3'd0, 1'b0});
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("bp release", {in_ready, out_valid}, 2'b10);
    x = 3'd7;
    y = 3'd2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    rst = 1'b0;
    chk("mid rst", {in_ready, out_valid, diff, bout, ovf}, {1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
    for (int i = 0; i < 5; i++) step();
    chk("mid rst quiet", {in_ready, out_valid}, 2'b10);
    out_ready = 1'b0;
    run_op("7-2", 3'd7, 3'd2, 0, 3'd5, 1'b0, 1'b0);
    accepts = 0;
    results = 0;
    for (int i = 0; i < 64; i++) begin
      logic [2:0] xv, yv, ed;
      xv = 3'(i >> 3);
      yv = 3'(i);
      ed = xv - yv;
      run_op("sweep", xv, yv, int'($urandom_range(0, 3)), ed, xv < yv,
             (xv[2] != yv[2]) && (ed[2] != xv[2]));
    end
    step();
    chk("accepts", accepts, 64);
    chk("results", results, 64);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
